// File: rtl/wb_cfg_arbiter.sv
// Round-robin arbiter that shares one pipelined Wishbone register slave between two
// single-beat requesters, with timeout-based error completion.
module wb_cfg_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req0_i,
  input  logic                  req0_we_i,
  input  logic [ADDR_WIDTH-1:0] req0_adr_i,
  input  logic [31:0]           req0_dat_i,
  output logic                  req0_ack_o,
  output logic                  req0_err_o,
  input  logic                  req1_i,
  input  logic                  req1_we_i,
  input  logic [ADDR_WIDTH-1:0] req1_adr_i,
  input  logic [31:0]           req1_dat_i,
  output logic                  req1_ack_o,
  output logic                  req1_err_o,
  output logic [31:0]           rsp_dat_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_stall_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                r_state;
  logic                  r_last_grant;
  logic                  r_grant;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic [31:0]           r_rsp_dat;
  logic [7:0]            r_tmo_cnt;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_err0;
  logic                  r_err1;

  logic w_grant;
  logic w_timeout;
  logic w_finish;
  logic w_fin_err;

  // With both pending, the port that did not win last time goes next.
  assign w_grant   = (req0_i && req1_i) ? ~r_last_grant : req1_i;
  assign w_timeout = (r_tmo_cnt == 8'(TIMEOUT - 1));
  assign w_finish  = wb_ack_i | wb_err_i | w_timeout;
  // err beats ack; ack beats a simultaneous timeout.
  assign w_fin_err = wb_err_i | (~wb_ack_i & w_timeout);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_rsp_dat    <= '0;
      r_tmo_cnt    <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req0_i || req1_i) begin
            r_grant   <= w_grant;
            r_we      <= w_grant ? req1_we_i  : req0_we_i;
            r_adr     <= w_grant ? req1_adr_i : req0_adr_i;
            r_dat     <= w_grant ? req1_dat_i : req0_dat_i;
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= StIssue;
          end
        end
        StIssue, StWait: begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
          if (w_finish) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= StDone;
            if (w_fin_err) begin
              r_err0 <= ~r_grant;
              r_err1 <= r_grant;
            end else begin
              r_ack0 <= ~r_grant;
              r_ack1 <= r_grant;
              if (!r_we) r_rsp_dat <= wb_dat_i;
            end
          end else if (r_state == StIssue && !wb_stall_i) begin
            r_stb   <= 1'b0;
            r_state <= StWait;
          end
        end
        StDone: begin
          r_last_grant <= r_grant;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req0_ack_o = r_ack0;
  assign req1_ack_o = r_ack1;
  assign req0_err_o = r_err0;
  assign req1_err_o = r_err1;
  assign rsp_dat_o  = r_rsp_dat;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_we;
  assign wb_sel_o   = r_cyc ? 4'hF : 4'h0;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;

endmodule

// File: tb/tb_wb_cfg_arbiter.sv
// Scoreboard bench for wb_cfg_arbiter: directed requests against a small WB slave model,
// a monitor pops the expected completion on every ack/err pulse.
module tb_wb_cfg_arbiter;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rsp;
  } exp_t;

  localparam logic [31:0] Junk = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [7:0]  adr [2];
  logic [31:0] dat [2];
  logic        ack0, ack1, err0, err1;
  logic [31:0] rsp;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_rdat;
  logic        wb_ack, wb_err, wb_stall;

  exp_t        sb[$];
  logic [31:0] mem [256];
  logic [31:0] m_rsp;
  int          n_tests = 0;
  int          n_fail = 0;
  int          pulse_cnt = 0;
  int          cyc_cnt = 0;
  int          last_pulse_cyc = 0;
  int          cyc_rise_cyc = 0;
  int          t_issue = 0;
  logic        cyc_prev = 1'b0;
  logic        prev_pulse = 1'b0;
  logic [7:0]  stall_adr = 8'h00;

  // Slave model controls
  logic        sl_silent = 1'b0;
  logic        sl_both = 1'b0;
  int          sl_stall_left = 0;
  logic        sl_accept = 1'b0;
  logic [7:0]  sl_adr = 8'h00;
  logic        sl_we = 1'b0;

  wb_cfg_arbiter #(.ADDR_WIDTH(8), .TIMEOUT(16)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req0_i     (req[0]),
    .req0_we_i  (we[0]),
    .req0_adr_i (adr[0]),
    .req0_dat_i (dat[0]),
    .req0_ack_o (ack0),
    .req0_err_o (err0),
    .req1_i     (req[1]),
    .req1_we_i  (we[1]),
    .req1_adr_i (adr[1]),
    .req1_dat_i (dat[1]),
    .req1_ack_o (ack1),
    .req1_err_o (err1),
    .rsp_dat_o  (rsp),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_we_o    (wb_we),
    .wb_sel_o   (wb_sel),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_rdat),
    .wb_ack_i   (wb_ack),
    .wb_err_i   (wb_err),
    .wb_stall_i (wb_stall)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave responses: ack one cycle after an unstalled strobe is accepted.
  initial begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_rdat = Junk;
    forever begin
      @(posedge clk); #1;
      wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = Junk;
      if (sl_accept) begin
        sl_accept = 1'b0;
        if (sl_both) begin
          wb_ack = 1'b1; wb_err = 1'b1; wb_rdat = mem[sl_adr];
        end else if (!sl_silent) begin
          wb_ack = 1'b1;
          if (!sl_we) wb_rdat = mem[sl_adr];
        end
      end
      wb_stall = 1'b0;
      if (wb_stb && sl_stall_left > 0) begin
        wb_stall = 1'b1;
        sl_stall_left--;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && wb_cyc && wb_stb && !wb_stall) begin
      sl_accept = 1'b1;
      sl_adr    = wb_adr;
      sl_we     = wb_we;
      if (wb_we) mem[wb_adr] = wb_dat_o;
    end
  end

  // Bus watcher: cycle-rise timestamp, sel, stability under stall.
  initial forever begin
    @(negedge clk);
    if (wb_cyc && !cyc_prev) begin
      cyc_rise_cyc = cyc_cnt;
      chk("sel_on_cyc", {28'd0, wb_sel}, 32'hF);
    end
    cyc_prev = wb_cyc;
    if (wb_cyc && wb_stall) begin
      chk("stall_stb", {31'd0, wb_stb}, 32'd1);
      chk("stall_adr", {24'd0, wb_adr}, {24'd0, stall_adr});
    end
  end

  // Monitor: every completion pulse pops one expected response.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && (ack0 || ack1 || err0 || err1)) begin
      chk("one_pulse", $countones({ack0, ack1, err0, err1}), 32'd1);
      chk("cyc_low_at_done", {31'd0, wb_cyc}, 32'd0);
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pulse: got ack=%b%b err=%b%b, expected none",
                 ack1, ack0, err1, err0);
      end else begin
        e = sb.pop_front();
        chk("grant_port", {31'd0, ack1 | err1}, {31'd0, e.port});
        chk("is_err", {31'd0, err0 | err1}, {31'd0, e.err});
        chk("rsp_dat", rsp, e.rsp);
      end
      pulse_cnt++;
      last_pulse_cyc = cyc_cnt;
      prev_pulse = 1'b1;
    end else if (prev_pulse) begin
      chk("idle_gap", {31'd0, wb_cyc}, 32'd0);
      prev_pulse = 1'b0;
    end
  end

  task automatic wait_pulses(input int target, input string name);
    int k = 0;
    while (pulse_cnt < target && k < 80) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, {31'd0, pulse_cnt >= target}, 32'd1);
  endtask

  task automatic do_req(input int p, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic e_err, input string name);
    exp_t e;
    if (!w && !e_err) m_rsp = mem[a];
    e.port = p[0]; e.err = e_err; e.rsp = m_rsp;
    sb.push_back(e);
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w; adr[p] = a; dat[p] = d;
    t_issue = cyc_cnt;
    wait_pulses(pulse_cnt + 1, name);
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   base;
    int   k;
    rst_n = 1'b0; req = 2'b00; we = 2'b00;
    adr[0] = 8'h00; adr[1] = 8'h00; dat[0] = '0; dat[1] = '0;
    m_rsp = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_sel", {28'd0, wb_sel}, 32'd0);
    chk("rst_pulses", {28'd0, ack0, ack1, err0, err1}, 32'd0);
    chk("rst_rsp", rsp, 32'd0);
    chk("rst_adr", {24'd0, wb_adr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, slave acks at cycle 2 -> ack pulse at cycle 3.
    do_req(0, 1'b1, 8'h00, 32'h1234_ABCD, 1'b0, "t1_done");
    chk("t1_cyc_latency", cyc_rise_cyc - t_issue, 32'd1);
    chk("t1_ack_latency", last_pulse_cyc - t_issue, 32'd3);
    chk("t1_threshold", {16'd0, mem[0][15:0]}, 32'h0000_ABCD);

    // Read stalled for 5 cycles.
    mem[8'h10] = 32'hDEAD_BEEF; stall_adr = 8'h10; sl_stall_left = 5;
    do_req(1, 1'b0, 8'h10, 32'h0, 1'b0, "t3_done");
    chk("t3_ack_latency", last_pulse_cyc - cyc_rise_cyc, 32'd7);
    chk("t3_rsp", rsp, 32'hDEAD_BEEF);

    // Both held for four transactions: alternation 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      e.port = i[0]; e.err = 1'b0; e.rsp = m_rsp;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    we = 2'b11; adr[0] = 8'h04; dat[0] = 32'h1111_1111; adr[1] = 8'h08; dat[1] = 32'h2222_2222;
    req = 2'b11;
    base = pulse_cnt;
    wait_pulses(base + 4, "t2_done");
    req = 2'b00;
    repeat (2) @(negedge clk);
    chk("t2_mem0", mem[8'h04], 32'h1111_1111);
    chk("t2_mem1", mem[8'h08], 32'h2222_2222);

    // Silent slave -> timeout error 16 cycles after cyc rise, rsp unchanged.
    sl_silent = 1'b1;
    do_req(0, 1'b0, 8'h20, 32'h0, 1'b1, "t4_done");
    sl_silent = 1'b0;
    chk("t4_tmo_latency", last_pulse_cyc - cyc_rise_cyc, 32'd16);

    // ack and err together -> err only, rsp unchanged.
    mem[8'h30] = 32'hCAFE_F00D; sl_both = 1'b1;
    do_req(0, 1'b0, 8'h30, 32'h0, 1'b1, "t5_done");
    sl_both = 1'b0;
    chk("t5_rsp_kept", rsp, 32'hDEAD_BEEF);

    // Async reset while in WAIT.
    sl_silent = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; adr[0] = 8'h40;
    k = 0;
    while (!(wb_cyc && !wb_stb) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_wait", {31'd0, wb_cyc && !wb_stb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("t6_async_stb", {31'd0, wb_stb}, 32'd0);
    chk("t6_async_sel", {28'd0, wb_sel}, 32'd0);
    req[0] = 1'b0; sl_silent = 1'b0;
    base = pulse_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_no_pulse", pulse_cnt, base);
    chk("t6_rsp_cleared", rsp, 32'd0);
    m_rsp = '0;
    for (int i = 0; i < 2; i++) begin
      e.port = i[0]; e.err = 1'b0; e.rsp = m_rsp;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    we = 2'b11; adr[0] = 8'h50; dat[0] = 32'h0A0A_0A0A; adr[1] = 8'h54; dat[1] = 32'h0B0B_0B0B;
    req = 2'b11;
    wait_pulses(base + 2, "t6_done");
    req = 2'b00;

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
